// File: rtl/idivmod_pkg.sv
// Shared definitions for the signed/unsigned divide front-end.
//   state_e   : front-end sequencing states
//   WIDTH_DEF : default operand/result width
//   DBZ_QUOT  : quotient returned on divide-by-zero (all ones)
//   SMIN      : most negative two's-complement value at the default width
package idivmod_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [WIDTH_DEF-1:0] DBZ_QUOT = '1;
    localparam logic [WIDTH_DEF-1:0] SMIN     = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_FIX,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/idivmod_frontend_if.sv
// Operand/result handshake bundle for idivmod_frontend.
//   in_valid/in_ready   : operand pair handshake (in_signed, in_dividend, in_divisor)
//   out_valid/out_ready : result handshake (out_quot, out_rem, out_dbz, out_err)
// master = operand producer / result consumer, slave = the front-end.
interface idivmod_frontend_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic             out_dbz;
    logic             out_err;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_err
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_dbz, out_err
    );

endinterface

// File: rtl/idivmod_frontend_sign_mag.sv
// Combinational sign/magnitude split.
//   x         : operand
//   is_signed : 1 = treat x as two's complement
//   mag       : |x| when signed, x otherwise (negation modulo 2^WIDTH)
//   neg       : x is negative (only ever set in signed mode)
module sign_mag #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    always_comb begin
        neg = is_signed & x[WIDTH-1];
        mag = neg ? (~x + WIDTH'(1)) : x;
    end

endmodule

// File: rtl/idivmod_frontend.sv
// Signed/unsigned front-end for the iterative divide/modulo core.
//   clk, reset          : clock, asynchronous active-high reset
//   bus (slave)         : operand and result valid/ready handshakes
//   core_rq             : one-cycle request pulse to the core
//   core_dividend/_divisor : operand magnitudes, stable from ISSUE until FIX
//   core_quot/_rem      : core results, captured on core_ack
//   core_ack            : core done (held high until the next request)
// Zero divisor and signed overflow bypass the core; a watchdog bounds WAIT.
module idivmod_frontend
    import idivmod_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = 128
) (
    input  logic              clk,
    input  logic              reset,
    idivmod_frontend_if.slave bus,
    output logic              core_rq,
    output logic [WIDTH-1:0]  core_dividend,
    output logic [WIDTH-1:0]  core_divisor,
    input  logic [WIDTH-1:0]  core_quot,
    input  logic [WIDTH-1:0]  core_rem,
    input  logic              core_ack
);

    localparam int unsigned      WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SMIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    state_e state_q, state_d;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             dbz_q, err_q;
    logic             neg_q_q, neg_r_q;
    logic [WIDTH-1:0] raw_quot_q, raw_rem_q;
    logic [WD_W-1:0]  wd_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;
    logic             accept, is_dbz, is_ovf;

    sign_mag #(.WIDTH(WIDTH)) u_sm_dividend (
        .x         (bus.in_dividend),
        .is_signed (bus.in_signed),
        .mag       (a_mag),
        .neg       (a_neg)
    );

    sign_mag #(.WIDTH(WIDTH)) u_sm_divisor (
        .x         (bus.in_divisor),
        .is_signed (bus.in_signed),
        .mag       (b_mag),
        .neg       (b_neg)
    );

    always_comb begin
        accept = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
        is_dbz = (bus.in_divisor == '0);
        is_ovf = bus.in_signed && (bus.in_dividend == SMIN_W) && (bus.in_divisor == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ARM exists so an ack still high from the previous operation (the core
    // clears it one cycle after rq) is never mistaken for completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (is_dbz || is_ovf) ? ST_HOLD : ST_ISSUE;
            ST_ISSUE: state_d = ST_ARM;
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_ack)            state_d = ST_FIX;
                else if (wd_q == WD_MAX) state_d = ST_HOLD;
            end
            ST_FIX:   state_d = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and request outputs are registered from the next state so
    // none of them depend combinationally on inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            core_rq       <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            dbz_q         <= 1'b0;
            err_q         <= 1'b0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            raw_quot_q    <= '0;
            raw_rem_q     <= '0;
            wd_q          <= '0;
        end else begin
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_HOLD);
            core_rq     <= (state_d == ST_ISSUE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        if (is_dbz) begin
                            quot_q <= '1;
                            rem_q  <= bus.in_dividend;
                            dbz_q  <= 1'b1;
                        end else if (is_ovf) begin
                            quot_q <= SMIN_W;
                            rem_q  <= '0;
                        end else begin
                            core_dividend <= a_mag;
                            core_divisor  <= b_mag;
                        end
                    end
                end
                ST_ARM: wd_q <= '0;
                ST_WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    if (core_ack) begin
                        raw_quot_q <= core_quot;
                        raw_rem_q  <= core_rem;
                    end else if (wd_q == WD_MAX) begin
                        quot_q <= '0;
                        rem_q  <= '0;
                        err_q  <= 1'b1;
                    end
                end
                ST_FIX: begin
                    quot_q <= neg_q_q ? (~raw_quot_q + WIDTH'(1)) : raw_quot_q;
                    rem_q  <= neg_r_q ? (~raw_rem_q + WIDTH'(1)) : raw_rem_q;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        dbz_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_quot  = quot_q;
    assign bus.out_rem   = rem_q;
    assign bus.out_dbz   = dbz_q;
    assign bus.out_err   = err_q;

endmodule
